// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- byte-serial memory controller arbitrating between an instruction
// fetch port and a load/store port onto a single 8-bit RAM interface.
//
// Every transaction moves N bytes, one per cycle, little-endian:
//   fetch         : always N = 4, read
//   load / store  : N = 1/2/4 for ls_size 0/1/2
// RAM read data returns one cycle after the address is presented. Stores to
// the I/O window (address >= IO_BASE) wait while io_buffer_full is high.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes all state
//   mem_din         RAM read byte (one cycle after mem_a)
//   mem_dout/mem_a  RAM write byte / byte address
//   mem_wr          RAM write strobe
//   io_buffer_full  I/O sink cannot take a write
//   if_*            fetch request / one-cycle completion with word
//   ls_*            load/store request / one-cycle completion with load data
//   flush           cancels an in-flight or pending fetch
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h00030000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic [31:0] ls_rdata,
  input  logic        flush
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        we_q, we_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic [31:0] byte_addr;
  logic [1:0]  cap_idx;
  logic        io_stall;

  // Address arithmetic wraps naturally at 32 bits.
  assign byte_addr = addr_q + {29'd0, k_q};
  // At step k the byte arriving on mem_din belongs to position k-1.
  assign cap_idx   = k_q[1:0] - 2'd1;
  assign io_stall  = io_buffer_full && (byte_addr >= IO_BASE);

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // State register. A low rdy simply skips the update, which freezes the
  // transaction exactly where it is.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      k_q        <= 3'd0;
      n_q        <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      k_q        <= k_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    k_d        = k_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    mem_a      = 32'd0;
    mem_dout   = 8'd0;
    mem_wr     = 1'b0;
    if_ready   = 1'b0;
    ls_ready   = 1'b0;
    if_data    = if_data_q;
    ls_rdata   = ls_rdata_q;

    case (state_q)
      IDLE: begin
        if (ls_req) begin
          owner_d = OWN_LS;
          we_d    = ls_we;
          addr_d  = ls_addr;
          n_d     = size_to_n(ls_size);
          wdata_d = ls_wdata;
          k_d     = 3'd0;
          rbuf_d  = 32'd0;
          state_d = ls_we ? WRITE : READ;
        end else if (if_req && !flush) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          n_d     = 3'd4;
          k_d     = 3'd0;
          rbuf_d  = 32'd0;
          state_d = READ;
        end
      end

      READ: begin
        // While frozen with a capture pending, keep presenting the previous
        // byte's address so mem_din still carries that byte on resume.
        if (!rdy && k_q != 3'd0) begin
          mem_a = byte_addr - 32'd1;
        end else if (k_q < n_q) begin
          mem_a = byte_addr;
        end
        if (k_q != 3'd0) begin
          rbuf_d[{cap_idx, 3'b000} +: 8] = mem_din;
        end
        if (k_q == n_q) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
        if (owner_q == OWN_IF && flush) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end
      end

      WRITE: begin
        mem_a    = byte_addr;
        mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy && !io_stall;
        if (!io_stall) begin
          if (k_q == n_q - 3'd1) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        k_d     = 3'd0;
        if (owner_q == OWN_IF) begin
          // A flush landing on the completion cycle still kills the pulse.
          if (!flush) begin
            if_ready  = rdy;
            if_data_d = rbuf_q;
            if (rdy) if_data = rbuf_q;
          end
        end else begin
          ls_ready = rdy;
          // Stores leave the last load value visible.
          if (!we_q) begin
            ls_rdata_d = rbuf_q;
            if (rdy) ls_rdata = rbuf_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- self-checking bench for mem_ctrl. A sparse byte RAM model
// drives mem_din; a separate reference memory predicts load data, store
// effects and completion latency from the transaction rules.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam logic [31:0] IO_BASE = 32'h00030000;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full, flush;
  logic        if_req, ls_req, ls_we;
  logic [1:0]  ls_size;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, if_data, ls_rdata;
  logic        mem_wr, if_ready, ls_ready;

  int checks = 0;
  int errors = 0;

  mem_ctrl #(.IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .flush(flush)
  );

  always #5 clk = ~clk;

  // ---------------- environment RAM and reference memory ----------------
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + i);
    return w;
  endfunction

  function automatic int size_n(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  // ---------------- transaction driver (records, does not judge) ----------------
  logic [31:0] trace_a    [64];
  logic        trace_wr   [64];
  logic [7:0]  trace_dout [64];
  int          viol;   // writes while frozen/full, or the wrong port pulsing

  task automatic txn(input bit is_if, input bit we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int roff_at, input int roff_len, input int full_len,
                     input bit flush_lvl,
                     output int lat, output logic [31:0] data, output int nwr);
    int cyc;
    bit done;
    nwr = 0; lat = -1; data = 32'd0; done = 0; viol = 0;
    for (int i = 0; i < 64; i++) begin
      trace_a[i] = 32'd0; trace_wr[i] = 1'b0; trace_dout[i] = 8'd0;
    end
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata;
      flush = flush_lvl;
    end
    rdy = 1'b1;
    io_buffer_full = (full_len > 0);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      rdy = !(cyc >= roff_at && cyc < roff_at + roff_len);
      io_buffer_full = (cyc <= full_len);
      #1;
      trace_a[cyc] = mem_a; trace_wr[cyc] = mem_wr; trace_dout[cyc] = mem_dout;
      if (mem_wr) begin
        if (!rdy || (io_buffer_full && mem_a >= IO_BASE)) viol++;
        nwr++;
      end
      if (is_if ? ls_ready : if_ready) viol++;
      if (is_if ? if_ready : ls_ready) begin
        lat = cyc;
        data = is_if ? if_data : ls_rdata;
        done = 1;
      end
    end
    if_req = 1'b0; ls_req = 1'b0; flush = 1'b0;
    rdy = 1'b1; io_buffer_full = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_a, mem_dout, mem_wr, if_ready, ls_ready, if_data, ls_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b ifr=%b lsr=%b if_data=%h ls_rdata=%h, all required 0",
               mem_a, mem_dout, mem_wr, if_ready, ls_ready, if_data, ls_rdata);
    end
    rst = 1'b0; rdy = 1'b1;
  endtask

  task automatic test_fetch_basic;
    int lat, nwr;
    logic [31:0] d;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05; ref_mem[32'h102] = 8'h10; ref_mem[32'h103] = 8'h00;
    txn(1, 0, 2'd2, 32'h100, 32'd0, 99, 0, 0, 0, lat, d, nwr);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (trace_a[c] !== 32'h100 + c - 1 || trace_wr[c] !== 1'b0) begin
        errors++;
        $display("FAIL fetch_addr_c%0d: mem_a=%h wr=%b, required %h wr=0", c, trace_a[c], trace_wr[c], 32'h100 + c - 1);
      end
    end
    checks++;
    if (lat !== 6 || d !== 32'h00100513) begin
      errors++;
      $display("FAIL fetch_basic: cycle=%0d data=%h, required cycle 6 data 00100513", lat, d);
    end
    // if_data must hold between pulses.
    repeat (5) @(negedge clk);
    checks++;
    if (if_data !== 32'h00100513 || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hold: if_data=%h if_ready=%b, required 00100513 / 0", if_data, if_ready);
    end
  endtask

  task automatic test_priority;
    int cyc, ls_cyc, if_cyc;
    logic [31:0] ls_d, if_d;
    ram[32'h200] = 8'hFF; ref_mem[32'h200] = 8'hFF;
    ls_cyc = -1; if_cyc = -1; ls_d = 32'd0; if_d = 32'd0;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300;
    cyc = 0;
    while (if_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      #1;
      if (ls_ready) begin ls_cyc = cyc; ls_d = ls_rdata; ls_req = 1'b0; end
      if (if_ready) begin
        if (ls_cyc < 0) ls_cyc = 99;
        if_cyc = cyc; if_d = if_data; if_req = 1'b0;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    checks++;
    if (ls_cyc !== 3 || ls_d !== 32'h000000FF) begin
      errors++;
      $display("FAIL priority_load: cycle=%0d data=%h, required cycle 3 data 000000ff", ls_cyc, ls_d);
    end
    // Fetch is accepted in the idle cycle after the load completes.
    checks++;
    if (if_cyc !== 10 || if_d !== ref_word(32'h300, 4)) begin
      errors++;
      $display("FAIL priority_fetch: cycle=%0d data=%h, required cycle 10 data %h", if_cyc, if_d, ref_word(32'h300, 4));
    end
  endtask

  task automatic test_store_word;
    int lat, nwr;
    logic [31:0] d;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    txn(0, 1, 2'd2, 32'h40, 32'hDEADBEEF, 99, 0, 0, 0, lat, d, nwr);
    for (int i = 0; i < 4; i++) ref_mem[32'h40 + i] = exp_b[i];
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (trace_wr[c] !== 1'b1 || trace_a[c] !== 32'h40 + c - 1 || trace_dout[c] !== exp_b[c-1]) begin
        errors++;
        $display("FAIL store_word_c%0d: wr=%b a=%h dout=%h, required 1 %h %h",
                 c, trace_wr[c], trace_a[c], trace_dout[c], 32'h40 + c - 1, exp_b[c-1]);
      end
    end
    checks++;
    if (lat !== 5 || nwr !== 4 || viol !== 0) begin
      errors++;
      $display("FAIL store_word: cycle=%0d writes=%0d viol=%0d, required 5 4 0", lat, nwr, viol);
    end
  endtask

  task automatic test_io_stall;
    int lat, nwr;
    logic [31:0] d;
    txn(0, 1, 2'd0, 32'h30000, 32'h00000041, 99, 0, 3, 0, lat, d, nwr);
    ref_mem[32'h30000] = 8'h41;
    checks++;
    if (trace_wr[1] !== 1'b0 || trace_wr[2] !== 1'b0 || trace_wr[3] !== 1'b0 || trace_wr[4] !== 1'b1) begin
      errors++;
      $display("FAIL io_stall_strobe: wr c1..c4=%b%b%b%b, required 0001",
               trace_wr[1], trace_wr[2], trace_wr[3], trace_wr[4]);
    end
    checks++;
    if (lat !== 5 || nwr !== 1 || viol !== 0 || ram_rd(32'h30000) !== 8'h41) begin
      errors++;
      $display("FAIL io_stall: cycle=%0d writes=%0d viol=%0d byte=%h, required 5 1 0 41",
               lat, nwr, viol, ram_rd(32'h30000));
    end
  endtask

  task automatic test_flush;
    int cyc, ls_cyc, seen_if, lat, nwr;
    logic [31:0] d, held;
    // Flush in READ at cycle 3; controller idle again at cycle 4.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    held = if_data;
    seen_if = 0; ls_cyc = -1;
    cyc = 0;
    while (ls_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin flush = 1'b1; if_req = 1'b0; end
      if (cyc == 4) begin
        flush = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h1000;
      end
      #1;
      if (if_ready) seen_if++;
      if (ls_ready) begin ls_cyc = cyc; d = ls_rdata; ls_req = 1'b0; end
    end
    ls_req = 1'b0;
    checks++;
    if (seen_if !== 0 || ls_cyc !== 10 || d !== ref_word(32'h1000, 4)) begin
      errors++;
      $display("FAIL flush_read: if_pulses=%0d load_cycle=%0d data=%h, required 0 10 %h",
               seen_if, ls_cyc, d, ref_word(32'h1000, 4));
    end
    // Flush on the completion cycle still suppresses the pulse.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1010;
    seen_if = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 6) begin flush = 1'b1; if_req = 1'b0; end
      if (c == 7) flush = 1'b0;
      #1;
      if (if_ready) seen_if++;
    end
    checks++;
    if (seen_if !== 0 || if_data !== held) begin
      errors++;
      $display("FAIL flush_done: if_pulses=%0d if_data=%h, required 0 %h", seen_if, if_data, held);
    end
    // Load with flush held high throughout is unaffected.
    txn(0, 0, 2'd1, 32'h1020, 32'd0, 99, 0, 0, 1, lat, d, nwr);
    checks++;
    if (lat !== 4 || d !== ref_word(32'h1020, 2)) begin
      errors++;
      $display("FAIL flush_load: cycle=%0d data=%h, required 4 %h", lat, d, ref_word(32'h1020, 2));
    end
  endtask

  task automatic test_rdy_stall;
    int lat, nwr;
    logic [31:0] d;
    txn(0, 0, 2'd2, 32'h1040, 32'd0, 2, 2, 0, 0, lat, d, nwr);
    checks++;
    if (lat !== 8 || d !== ref_word(32'h1040, 4) || viol !== 0) begin
      errors++;
      $display("FAIL rdy_stall: cycle=%0d data=%h viol=%0d, required 8 %h 0", lat, d, viol, ref_word(32'h1040, 4));
    end
  endtask

  task automatic test_wrap;
    int lat, nwr;
    logic [31:0] d;
    txn(0, 0, 2'd2, 32'hFFFFFFFE, 32'd0, 99, 0, 0, 0, lat, d, nwr);
    checks++;
    if (lat !== 6 || d !== ref_word(32'hFFFFFFFE, 4)) begin
      errors++;
      $display("FAIL wrap_load: cycle=%0d data=%h, required 6 %h", lat, d, ref_word(32'hFFFFFFFE, 4));
    end
  endtask

  task automatic test_reset_mid_store;
    int seen, lat, nwr;
    logic [31:0] d;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h8000; ls_wdata = 32'hCAFEBABE;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; ls_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_a, mem_dout, mem_wr, if_ready, ls_ready, ls_rdata, if_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_store: a=%h dout=%h wr=%b ifr=%b lsr=%b ls_rdata=%h if_data=%h, all required 0",
               mem_a, mem_dout, mem_wr, if_ready, ls_ready, ls_rdata, if_data);
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (ls_ready || mem_wr) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_ready: stray events=%0d, required 0", seen);
    end
    txn(0, 0, 2'd1, 32'h1050, 32'd0, 99, 0, 0, 0, lat, d, nwr);
    checks++;
    if (lat !== 4 || d !== ref_word(32'h1050, 2)) begin
      errors++;
      $display("FAIL reset_after: cycle=%0d data=%h, required 4 %h", lat, d, ref_word(32'h1050, 2));
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 30; it++) begin
      int kind, n, roff_at, roff_len, full_len, exp_lat, lat, nwr, bad;
      bit fl;
      logic [1:0] size;
      logic [31:0] addr, wdata, d;
      kind = $urandom_range(0, 3);
      size = (kind == 0) ? 2'd2 : 2'($urandom_range(0, 2));
      n = size_n(size);
      addr = (kind == 3) ? IO_BASE + $urandom_range(0, 63) : 32'h1000 + $urandom_range(0, 255);
      wdata = $urandom;
      roff_at = 99; roff_len = 0; full_len = 0;
      if (kind == 3) full_len = $urandom_range(0, 4);
      else if ($urandom_range(0, 1) == 1) begin
        roff_at = $urandom_range(1, n);
        roff_len = $urandom_range(1, 3);
      end
      fl = (kind != 0) && ($urandom_range(0, 1) == 1);
      exp_lat = ((kind >= 2) ? n + 1 : n + 2) + roff_len + full_len;
      txn(kind == 0, kind >= 2, size, addr, wdata, roff_at, roff_len, full_len, fl, lat, d, nwr);
      if (kind >= 2) begin
        for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        bad = 0;
        for (int i = 0; i < n; i++) if (ram_rd(addr + i) !== ref_rd(addr + i)) bad++;
        checks++;
        if (lat !== exp_lat || nwr !== n || bad !== 0 || viol !== 0) begin
          errors++;
          $display("FAIL rand_store%0d: addr=%h cycle=%0d writes=%0d bad_bytes=%0d viol=%0d, required %0d %0d 0 0",
                   it, addr, lat, nwr, bad, viol, exp_lat, n);
        end
      end else begin
        checks++;
        if (lat !== exp_lat || d !== ref_word(addr, n) || nwr !== 0 || viol !== 0) begin
          errors++;
          $display("FAIL rand_read%0d: addr=%h cycle=%0d data=%h writes=%0d viol=%0d, required %0d %h 0 0",
                   it, addr, lat, d, nwr, viol, exp_lat, ref_word(addr, n));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    test_reset();
    test_fetch_basic();
    test_priority();
    test_store_word();
    test_io_stall();
    test_flush();
    test_rdy_stall();
    test_wrap();
    test_reset_mid_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
